// File: rtl/crc_fcs_inserter.sv
// Appends an Ethernet FCS (CRC32, LSB first) to each frame, zero-padding short payloads to MIN_FRAME_LEN.
// Define CRC_FCS_STATS_EN to add the frame_count output.
`timescale 1ns/1ps

module crc32_lfsr8 (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    // Reflected form of polynomial 32'h04C11DB7
    localparam logic [31:0] POLY_REV = 32'hEDB88320;

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++)
            w_c = w_c[0] ? ((w_c >> 1) ^ POLY_REV) : (w_c >> 1);
    end

    assign o_crc = w_c;
endmodule

module crc_fcs_inserter #(
    parameter int unsigned MIN_FRAME_LEN = 60,
    parameter logic [31:0] CRC_INIT      = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy
`ifdef CRC_FCS_STATS_EN
    ,
    output logic [15:0] frame_count
`endif
);
    localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LEN);

    typedef enum logic [1:0] {ST_DATA = 2'd0, ST_PAD = 2'd1, ST_FCS = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_crc;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [7:0]  r_tdata;
    logic        r_tvalid, r_tlast;
    logic        r_armed;

    logic        w_slot_free;
    logic [16:0] w_cnt_inc;
    logic [31:0] w_crc_next, w_fcs;
    logic [7:0]  w_fcs_byte;
    logic        w_s_tready;
    logic        w_load, w_load_vld, w_load_last;
    logic [7:0]  w_load_data;
    logic        w_crc_upd, w_crc_rst, w_cnt_upd, w_cnt_clr, w_idx_upd;

    assign w_slot_free = !r_tvalid || m_tready;
    assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
    assign w_fcs       = ~r_crc;
    assign w_fcs_byte  = w_fcs[{r_idx, 3'b000} +: 8];

    // Pad bytes go through the same LFSR path as payload, with w_load_data forced to zero
    crc32_lfsr8 u_lfsr (
        .i_crc  (r_crc),
        .i_data (w_load_data),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_DATA;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DATA: if (w_s_tready && s_tvalid && s_tlast)
                         w_state_nxt = (w_cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
            ST_PAD:  if (w_slot_free && w_cnt_inc >= MIN_LEN) w_state_nxt = ST_FCS;
            ST_FCS:  if (w_slot_free && r_idx == 2'd3) w_state_nxt = ST_DATA;
            default: w_state_nxt = ST_DATA;
        endcase
    end

    always_comb begin
        w_s_tready  = 1'b0;
        w_load      = 1'b0;
        w_load_vld  = 1'b0;
        w_load_data = 8'h00;
        w_load_last = 1'b0;
        w_crc_upd   = 1'b0;
        w_crc_rst   = 1'b0;
        w_cnt_upd   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_idx_upd   = 1'b0;
        case (r_state)
            ST_DATA: if (r_armed && w_slot_free) begin
                w_s_tready  = 1'b1;
                w_load      = 1'b1;
                w_load_vld  = s_tvalid;
                w_load_data = s_tdata;
                w_crc_upd   = s_tvalid;
                w_cnt_upd   = s_tvalid;
            end
            ST_PAD: if (w_slot_free) begin
                w_load     = 1'b1;
                w_load_vld = 1'b1;
                w_crc_upd  = 1'b1;
                w_cnt_upd  = 1'b1;
            end
            ST_FCS: if (w_slot_free) begin
                w_load      = 1'b1;
                w_load_vld  = 1'b1;
                w_load_data = w_fcs_byte;
                w_load_last = (r_idx == 2'd3);
                w_idx_upd   = 1'b1;
                w_crc_rst   = (r_idx == 2'd3);
                w_cnt_clr   = (r_idx == 2'd3);
            end
            default: ;
        endcase
    end

    // r_armed keeps s_tready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata  <= 8'h00;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_crc    <= CRC_INIT;
            r_cnt    <= 16'h0000;
            r_idx    <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_load) begin
                r_tvalid <= w_load_vld;
                r_tlast  <= w_load_last;
                if (w_load_vld) r_tdata <= w_load_data;
            end
            if (w_crc_rst)      r_crc <= CRC_INIT;
            else if (w_crc_upd) r_crc <= w_crc_next;
            if (w_cnt_clr)                            r_cnt <= 16'h0000;
            else if (w_cnt_upd && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            if (w_idx_upd) r_idx <= r_idx + 2'd1;
        end
    end

    assign s_tready = w_s_tready;
    assign m_tdata  = r_tdata;
    assign m_tvalid = r_tvalid;
    assign m_tlast  = r_tlast;
    assign busy     = (r_state != ST_DATA);

`ifdef CRC_FCS_STATS_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_frame_count <= 16'h0000;
        else if (r_tvalid && m_tready && r_tlast) r_frame_count <= r_frame_count + 16'd1;
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_crc_fcs_inserter.sv
// Bench for crc_fcs_inserter: two instances (MIN_FRAME_LEN 1 and 60) checked against a frame-level CRC model.
`timescale 1ns/1ps

module tb_crc_fcs_inserter;
    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  d;
        logic        l;
    } ob_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_tdata [2];
    logic       s_tvalid [2];
    logic       s_tready [2];
    logic       s_tlast [2];
    logic [7:0] m_tdata [2];
    logic       m_tvalid [2];
    logic       m_tready [2];
    logic       m_tlast [2];
    logic       busy [2];
`ifdef CRC_FCS_STATS_EN
    logic [15:0] frame_count [2];
`endif

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] cyc    = 0;
    bit          rnd_rdy [2];
    int          stall_err [2];
    int          rdy_err [2];
    logic        hold_v [2];
    logic [7:0]  hold_d [2];
    logic        hold_l [2];
    ob_t         cap_q [2][$];
    logic [7:0]  tx_q [$];
    logic [8:0]  exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_fcs_inserter #(.MIN_FRAME_LEN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tlast(s_tlast[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tlast(m_tlast[0]),
        .busy(busy[0])
`ifdef CRC_FCS_STATS_EN
        , .frame_count(frame_count[0])
`endif
    );

    crc_fcs_inserter #(.MIN_FRAME_LEN(60)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tlast(s_tlast[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tlast(m_tlast[1]),
        .busy(busy[1])
`ifdef CRC_FCS_STATS_EN
        , .frame_count(frame_count[1])
`endif
    );

    // Downstream ready: always 1, or a coin flip per cycle when rnd_rdy is set
    initial begin
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                m_tready[d] = rnd_rdy[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output capture plus stall-stability and busy/ready watchdogs
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                if (m_tvalid[d] && m_tready[d]) cap_q[d].push_back({cyc, m_tdata[d], m_tlast[d]});
                if (hold_v[d] && (m_tvalid[d] !== 1'b1 || m_tdata[d] !== hold_d[d] || m_tlast[d] !== hold_l[d]))
                    stall_err[d] <= stall_err[d] + 1;
                if (busy[d] && s_tready[d]) rdy_err[d] <= rdy_err[d] + 1;
            end
            hold_v[d] <= rst_n && m_tvalid[d] && !m_tready[d];
            hold_d[d] <= m_tdata[d];
            hold_l[d] <= m_tlast[d];
        end
    end

    task automatic drive_byte(input int d, input logic [7:0] b, input bit last, input bit gaps);
        int n;
        if (gaps) begin
            s_tvalid[d] = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        s_tvalid[d] = 1'b1;
        s_tdata[d]  = b;
        s_tlast[d]  = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready[d] && n < 2000);
        @(posedge clk); #1;
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
        if (n >= 2000) begin
            checks++; fails++;
            $display("FAIL drive_timeout dut%0d: s_tready stayed 0 for %0d cycles, required 1", d, n);
        end
    endtask

    task automatic send_frame(input int d, input bit gaps, input bit with_last);
        for (int i = 0; i < tx_q.size(); i++)
            drive_byte(d, tx_q[i], with_last && (i == tx_q.size() - 1), gaps);
    endtask

    task automatic wait_cap(input int d, input int n);
        int t = 0;
        while (cap_q[d].size() < n && t < 3000) begin @(negedge clk); t++; end
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic load_ascii();
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    task automatic set_exp_123();
        exp_q.delete();
        foreach (tx_q[i]) exp_q.push_back({tx_q[i], 1'b0});
        exp_q.push_back({8'h26, 1'b0});
        exp_q.push_back({8'h39, 1'b0});
        exp_q.push_back({8'hF4, 1'b0});
        exp_q.push_back({8'hCB, 1'b1});
    endtask

    // Frame model: pad to minlen, bitwise CRC over the whole frame, append ~CRC LSB first
    task automatic build_exp(input int minlen);
        logic [7:0]  fr [$];
        logic [31:0] c;
        fr = tx_q;
        while (fr.size() < minlen) fr.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            c = c ^ {24'h0, fr[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        exp_q.delete();
        foreach (fr[i]) exp_q.push_back({fr[i], 1'b0});
        for (int k = 0; k < 4; k++) exp_q.push_back({c[8*k +: 8], k == 3});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (m_tvalid[d] !== 1'b0) begin fails++; $display("FAIL rst_m_tvalid dut%0d: got %b exp 0", d, m_tvalid[d]); end
            checks++; if (m_tlast[d] !== 1'b0)  begin fails++; $display("FAIL rst_m_tlast dut%0d: got %b exp 0", d, m_tlast[d]); end
            checks++; if (m_tdata[d] !== 8'h00) begin fails++; $display("FAIL rst_m_tdata dut%0d: got %h exp 00", d, m_tdata[d]); end
            checks++; if (s_tready[d] !== 1'b0) begin fails++; $display("FAIL rst_s_tready dut%0d: got %b exp 0", d, s_tready[d]); end
            checks++; if (busy[d] !== 1'b0)     begin fails++; $display("FAIL rst_busy dut%0d: got %b exp 0", d, busy[d]); end
`ifdef CRC_FCS_STATS_EN
            checks++; if (frame_count[d] !== 16'd0) begin fails++; $display("FAIL rst_frame_count dut%0d: got %0d exp 0", d, frame_count[d]); end
`endif
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        checks++; if (s_tready[0] !== 1'b0) begin fails++; $display("FAIL tready_before_edge: got %b exp 0", s_tready[0]); end
        @(posedge clk); #1;
        checks++; if (s_tready[0] !== 1'b1) begin fails++; $display("FAIL tready_after_edge: got %b exp 1", s_tready[0]); end
    endtask

    task automatic test_known_vector();
        cap_q[0].delete();
        load_ascii();
        send_frame(0, 1'b0, 1'b1);
        wait_cap(0, 13);
        set_exp_123();
        checks++; if (cap_q[0].size() !== exp_q.size()) begin fails++; $display("FAIL known_len: got %0d exp %0d", cap_q[0].size(), exp_q.size()); end
        for (int i = 0; i < cap_q[0].size() && i < exp_q.size(); i++) begin
            checks++;
            if ({cap_q[0][i].d, cap_q[0][i].l} !== exp_q[i]) begin
                fails++; $display("FAIL known byte %0d: got %h/%b exp %h/%b", i, cap_q[0][i].d, cap_q[0][i].l, exp_q[i][8:1], exp_q[i][0]);
            end
        end
    endtask

    task automatic test_pad();
        cap_q[1].delete();
        load_ascii();
        send_frame(1, 1'b0, 1'b1);
        checks++; if (busy[1] !== 1'b1)     begin fails++; $display("FAIL pad_busy: got %b exp 1", busy[1]); end
        checks++; if (s_tready[1] !== 1'b0) begin fails++; $display("FAIL pad_tready: got %b exp 0", s_tready[1]); end
        wait_cap(1, 64);
        build_exp(60);
        checks++; if (cap_q[1].size() !== 64) begin fails++; $display("FAIL pad_len: got %0d exp 64", cap_q[1].size()); end
        for (int i = 0; i < cap_q[1].size() && i < exp_q.size(); i++) begin
            checks++;
            if ({cap_q[1][i].d, cap_q[1][i].l} !== exp_q[i]) begin
                fails++; $display("FAIL pad byte %0d: got %h/%b exp %h/%b", i, cap_q[1][i].d, cap_q[1][i].l, exp_q[i][8:1], exp_q[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ref_b [5];
        ref_b = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        cap_q[0].delete();
        tx_q = '{8'h00};
        send_frame(0, 1'b0, 1'b1);
        send_frame(0, 1'b0, 1'b1);
        wait_cap(0, 10);
        checks++; if (cap_q[0].size() !== 10) begin fails++; $display("FAIL b2b_len: got %0d exp 10", cap_q[0].size()); end
        for (int i = 0; i < cap_q[0].size() && i < 10; i++) begin
            checks++;
            if ({cap_q[0][i].d, cap_q[0][i].l} !== {ref_b[i % 5], (i % 5) == 4}) begin
                fails++; $display("FAIL b2b byte %0d: got %h/%b exp %h/%b", i, cap_q[0][i].d, cap_q[0][i].l, ref_b[i % 5], (i % 5) == 4);
            end
        end
        if (cap_q[0].size() == 10) begin
            checks++;
            if (cap_q[0][9].cyc - cap_q[0][0].cyc !== 32'd9) begin
                fails++; $display("FAIL b2b_gapless: got span %0d cycles exp 9", cap_q[0][9].cyc - cap_q[0][0].cyc);
            end
        end
    endtask

    task automatic test_stall();
        stall_err[1] = 0;
        rdy_err[1]   = 0;
        rnd_rdy[1]   = 1'b1;
        cap_q[1].delete();
        load_ascii();
        send_frame(1, 1'b1, 1'b1);
        wait_cap(1, 64);
        rnd_rdy[1] = 1'b0;
        build_exp(60);
        checks++; if (cap_q[1].size() !== exp_q.size()) begin fails++; $display("FAIL stall_len: got %0d exp %0d", cap_q[1].size(), exp_q.size()); end
        for (int i = 0; i < cap_q[1].size() && i < exp_q.size(); i++) begin
            checks++;
            if ({cap_q[1][i].d, cap_q[1][i].l} !== exp_q[i]) begin
                fails++; $display("FAIL stall byte %0d: got %h/%b exp %h/%b", i, cap_q[1][i].d, cap_q[1][i].l, exp_q[i][8:1], exp_q[i][0]);
            end
        end
        checks++; if (stall_err[1] !== 0) begin fails++; $display("FAIL stall_hold: got %0d unstable cycles exp 0", stall_err[1]); end
        checks++; if (rdy_err[1] !== 0)   begin fails++; $display("FAIL busy_tready: got %0d cycles exp 0", rdy_err[1]); end
    endtask

    task automatic test_random_frames();
        int d, len, minlen;
        stall_err[0] = 0; stall_err[1] = 0;
        for (int f = 0; f < 5; f++) begin
            d      = (f == 4) ? 0 : 1;
            minlen = (d == 0) ? 1 : 60;
            len    = (f % 2 == 1) ? $urandom_range(60, 100) : $urandom_range(1, 59);
            rnd_rdy[d] = 1'b1;
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            cap_q[d].delete();
            send_frame(d, 1'b1, 1'b1);
            build_exp(minlen);
            wait_cap(d, exp_q.size());
            rnd_rdy[d] = 1'b0;
            checks++; if (cap_q[d].size() !== exp_q.size()) begin fails++; $display("FAIL rand%0d_len: got %0d exp %0d", f, cap_q[d].size(), exp_q.size()); end
            for (int i = 0; i < cap_q[d].size() && i < exp_q.size(); i++) begin
                checks++;
                if ({cap_q[d][i].d, cap_q[d][i].l} !== exp_q[i]) begin
                    fails++; $display("FAIL rand%0d byte %0d: got %h/%b exp %h/%b", f, i, cap_q[d][i].d, cap_q[d][i].l, exp_q[i][8:1], exp_q[i][0]);
                end
            end
        end
        checks++; if (stall_err[0] + stall_err[1] !== 0) begin fails++; $display("FAIL rand_hold: got %0d unstable cycles exp 0", stall_err[0] + stall_err[1]); end
    endtask

    task automatic test_reset_midframe();
        tx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        send_frame(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid[0] !== 1'b0) begin fails++; $display("FAIL midrst_m_tvalid: got %b exp 0", m_tvalid[0]); end
        checks++; if (s_tready[0] !== 1'b0) begin fails++; $display("FAIL midrst_s_tready: got %b exp 0", s_tready[0]); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cap_q[0].delete();
        repeat (6) @(posedge clk); #1;
        checks++; if (cap_q[0].size() !== 0) begin fails++; $display("FAIL midrst_no_fcs: got %0d bytes exp 0", cap_q[0].size()); end
        load_ascii();
        send_frame(0, 1'b0, 1'b1);
        wait_cap(0, 13);
        set_exp_123();
        checks++; if (cap_q[0].size() !== exp_q.size()) begin fails++; $display("FAIL midrst_len: got %0d exp %0d", cap_q[0].size(), exp_q.size()); end
        for (int i = 0; i < cap_q[0].size() && i < exp_q.size(); i++) begin
            checks++;
            if ({cap_q[0][i].d, cap_q[0][i].l} !== exp_q[i]) begin
                fails++; $display("FAIL midrst byte %0d: got %h/%b exp %h/%b", i, cap_q[0][i].d, cap_q[0][i].l, exp_q[i][8:1], exp_q[i][0]);
            end
        end
    endtask

    task automatic test_stats();
`ifdef CRC_FCS_STATS_EN
        apply_reset();
        cap_q[0].delete();
        load_ascii();
        for (int f = 0; f < 3; f++) send_frame(0, 1'b0, 1'b1);
        wait_cap(0, 39);
        checks++; if (frame_count[0] !== 16'd3) begin fails++; $display("FAIL stats_count: got %0d exp 3", frame_count[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (frame_count[0] !== 16'd0) begin fails++; $display("FAIL stats_reset: got %0d exp 0", frame_count[0]); end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_tdata[d]   = 8'h00;
            s_tvalid[d]  = 1'b0;
            s_tlast[d]   = 1'b0;
            rnd_rdy[d]   = 1'b0;
            stall_err[d] = 0;
            rdy_err[d]   = 0;
        end
        test_reset();
        test_known_vector();
        test_pad();
        test_back_to_back();
        test_stall();
        test_random_frames();
        test_reset_midframe();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/crc_fcs_inserter.md
CRC_FCS_INSERTER -- requirements
Module: crc_fcs_inserter

Interface
REQ-001 SHALL have parameter MIN_FRAME_LEN, default 60, meaning minimum payload bytes before FCS; shorter frames are zero-padded up to it; range 1..65535.
REQ-002 SHALL have parameter CRC_INIT, default 32'hFFFFFFFF, meaning CRC register value at frame start.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_tdata, input, 8, meaning payload byte in.
REQ-006 SHALL have port s_tvalid, input, 1, meaning payload byte valid.
REQ-007 SHALL have port s_tready, output, 1, meaning block accepts a payload byte.
REQ-008 SHALL have port s_tlast, input, 1, meaning last payload byte of the frame.
REQ-009 SHALL have port m_tdata, output, 8, meaning frame byte out.
REQ-010 SHALL have port m_tvalid, output, 1, meaning output byte valid.
REQ-011 SHALL have port m_tready, input, 1, meaning downstream accepts a byte.
REQ-012 SHALL have port m_tlast, output, 1, meaning last FCS byte of the frame.
REQ-013 SHALL have port busy, output, 1, meaning state is PAD or FCS.

Function
REQ-014 SHALL compute Ethernet CRC32 with a combinational 8-bit-per-cycle LFSR instance:
- Galois form, bit-reversed, polynomial 32'h04c11db7.
- FCS = bitwise inverse of the final CRC, emitted least-significant byte first.
REQ-015 SHALL use a single output register; it loads when m_tvalid==0 or m_tready==1 ("slot free").
REQ-016 SHALL implement states DATA (reset state), PAD and FCS.
REQ-017 In DATA, s_tready SHALL equal slot free.
REQ-018 In DATA, an accepted byte SHALL appear on m_tdata the next cycle (1-cycle latency) and SHALL update the CRC.
REQ-019 In PAD and FCS, s_tready SHALL be 0.
REQ-020 Byte counter (16 bits, saturating at 65535) SHALL count payload and pad bytes and SHALL clear on entry to DATA.
REQ-021 On an accepted byte with s_tlast=1, the next state SHALL be:
- PAD if counter+1 < MIN_FRAME_LEN;
- FCS otherwise.
REQ-022 PAD SHALL load one 8'h00 byte per free slot through the CRC, and SHALL go to FCS when the counter reaches MIN_FRAME_LEN.
REQ-023 FCS SHALL load 4 bytes, one per free slot, using a 2-bit index.
REQ-024 m_tlast SHALL be 1 only with FCS byte 3.
REQ-025 After FCS byte 3 is loaded, the block SHALL:
- reload the CRC with CRC_INIT;
- clear the counter;
- enter DATA.
REQ-026 While m_tvalid=1 and m_tready=0, m_tdata, m_tvalid and m_tlast SHALL hold stable, and the state, CRC and counter SHALL not advance.
REQ-027 Back-to-back frames SHALL be supported: the first byte of the next frame may load in the cycle after FCS byte 3 is accepted.
REQ-028 s_tvalid gaps inside a frame SHALL produce m_tvalid gaps only, with no CRC corruption.

Reset
REQ-029 While rst_n=0, the block SHALL set: m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, busy=0, state=DATA, counter=0, CRC=CRC_INIT.
REQ-030 A reset mid-frame SHALL drop the partial frame with no FCS emitted; the first accepted byte after release starts a new frame.
REQ-031 s_tready SHALL stay 0 until the first clock edge after rst_n deasserts.

Configuration
REQ-032 With macro CRC_FCS_STATS_EN defined, the block SHALL add output frame_count[15:0]:
- increments, wrapping, each time FCS byte 3 is accepted downstream;
- resets to 0.
REQ-033 Without CRC_FCS_STATS_EN, frame_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 MIN_FRAME_LEN=1; ASCII "123456789" with tlast on '9'; m_tready=1 -> output is the 9 bytes, then 26 39 F4 CB, tlast on CB.
REQ-035 MIN_FRAME_LEN=60; same 9 bytes -> 9 data bytes, then 51 bytes of 00, then the 4 CRC32 bytes of the 60-byte frame; 64 bytes total; tlast only on byte 64.
REQ-036 Back-to-back: one-byte frame 0x00 repeated twice, MIN_FRAME_LEN=1 -> each frame is 00 8D EF 02 D2, with no idle cycle required between frames.
REQ-037 Random m_tready (50%) on REQ-035 stimulus -> identical byte stream; m_* stable whenever stalled.
REQ-038 rst_n pulsed low after 5 payload bytes, then "123456789" sent -> no FCS from the aborted frame; second frame matches REQ-034.
REQ-039 With CRC_FCS_STATS_EN, 3 frames sent -> frame_count=3; reset -> 0.
